// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the five-stage pipeline
// Decides load/hold/bubble for PC and stage registers; keeps perf counters.
module pipe_hazard_ctrl #(
   parameter int RegIdWidth = 5,
   parameter int TIMEOUT    = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [RegIdWidth-1:0] i_id_rs1,
   input  logic [RegIdWidth-1:0] i_id_rs2,
   input  logic                  i_id_rs1_used,
   input  logic                  i_id_rs2_used,
   input  logic                  i_ex_valid,
   input  logic                  i_ex_is_load,
   input  logic [RegIdWidth-1:0] i_ex_rd,
   input  logic                  i_ex_redirect,
   input  logic                  i_mem_req,
   input  logic                  i_mem_ready,
   output logic                  o_pc_wen,
   output logic                  o_if_id_wen,
   output logic                  o_id_ex_wen,
   output logic                  o_ex_mem_wen,
   output logic                  o_mem_wb_wen,
   output logic                  o_if_id_flush,
   output logic                  o_id_ex_flush,
   output logic                  o_ex_mem_flush,
   output logic                  o_mem_wb_flush,
   output logic                  o_mem_timeout,
   output logic [CNT_WIDTH-1:0]  o_stall_cnt,
   output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT     = 2'd2;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   logic [1:0]           r_state;
   logic [WW-1:0]        r_wait_cnt;
   logic                 r_mem_timeout;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;

   logic w_mem_stall;
   logic w_load_use;
   logic w_halt;
   logic w_redirect_fire;

   assign w_mem_stall = i_mem_req & ~i_mem_ready;
   assign w_load_use  = i_ex_valid & i_ex_is_load & (i_ex_rd != '0) &
                        ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                         (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
   // While reset is asserted the outputs behave as in RUN, even from HALT.
   assign w_halt          = (r_state == ST_HALT) & ~i_rst;
   assign w_redirect_fire = ~w_halt & ~w_mem_stall & i_ex_redirect;

   always_comb begin
      o_pc_wen       = 1'b1;
      o_if_id_wen    = 1'b1;
      o_id_ex_wen    = 1'b1;
      o_ex_mem_wen   = 1'b1;
      o_mem_wb_wen   = 1'b1;
      o_if_id_flush  = 1'b0;
      o_id_ex_flush  = 1'b0;
      o_ex_mem_flush = 1'b0;
      o_mem_wb_flush = 1'b0;
      if (w_halt) begin
         o_pc_wen     = 1'b0;
         o_if_id_wen  = 1'b0;
         o_id_ex_wen  = 1'b0;
         o_ex_mem_wen = 1'b0;
         o_mem_wb_wen = 1'b0;
      end else if (w_mem_stall) begin
         o_pc_wen       = 1'b0;
         o_if_id_wen    = 1'b0;
         o_id_ex_wen    = 1'b0;
         o_ex_mem_wen   = 1'b0;
         o_mem_wb_flush = 1'b1;
      end else if (i_ex_redirect) begin
         o_if_id_flush = 1'b1;
         o_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
         o_pc_wen      = 1'b0;
         o_if_id_wen   = 1'b0;
         o_id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= '0;
         r_flush_cnt   <= '0;
      end else begin
         if (!o_pc_wen)
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         if (w_redirect_fire)
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
         case (r_state)
            ST_RUN: begin
               if (w_mem_stall) begin
                  r_state    <= ST_MEM_WAIT;
                  r_wait_cnt <= WW'(1);
               end
            end
            ST_MEM_WAIT: begin
               // A dropped request counts as release, same as a response.
               if (!w_mem_stall) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_state       <= ST_HALT;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WW'(1);
               end
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign o_mem_timeout = r_mem_timeout;
   assign o_stall_cnt   = r_stall_cnt;
   assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
// Reduced TIMEOUT=4 and CNT_WIDTH=4 so hang and counter wrap are reachable.
module tb_pipe_hazard_ctrl;

   localparam int RW = 5;
   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] rs1, rs2, exrd;
   logic          u1, u2, exv, exl, redir, mreq, mrdy;
   logic          pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
   logic          if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
   logic          tmo;
   logic [CW-1:0] scnt, fcnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RegIdWidth(RW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_id_rs1(rs1), .i_id_rs2(rs2),
      .i_id_rs1_used(u1), .i_id_rs2_used(u2),
      .i_ex_valid(exv), .i_ex_is_load(exl), .i_ex_rd(exrd),
      .i_ex_redirect(redir), .i_mem_req(mreq), .i_mem_ready(mrdy),
      .o_pc_wen(pc_wen), .o_if_id_wen(if_id_wen), .o_id_ex_wen(id_ex_wen),
      .o_ex_mem_wen(ex_mem_wen), .o_mem_wb_wen(mem_wb_wen),
      .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl),
      .o_ex_mem_flush(ex_mem_fl), .o_mem_wb_flush(mem_wb_fl),
      .o_mem_timeout(tmo), .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
   );

   typedef struct {
      logic [8:0]    ctl;
      logic          tmo;
      logic [CW-1:0] scnt;
      logic [CW-1:0] fcnt;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_err    = 0;

   // reference model state: 0 RUN, 1 MEM_WAIT, 2 HALT
   int            m_state = 0;
   int            m_wait  = 0;
   logic          m_tmo   = 1'b0;
   logic [CW-1:0] m_scnt  = '0;
   logic [CW-1:0] m_fcnt  = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: predict, push, compare at negedge, advance model.
   task automatic cyc();
      exp_t e, o;
      logic halt, mstall, lu, fire;
      int            n_state, n_wait;
      logic          n_tmo;
      logic [CW-1:0] n_scnt, n_fcnt;
      halt   = (m_state == 2) && !rst;
      mstall = mreq && !mrdy;
      lu     = exv && exl && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
      fire   = 1'b0;
      if (halt)        e.ctl = 9'b00000_0000;
      else if (mstall) e.ctl = 9'b00001_0001;
      else if (redir) begin
         e.ctl = 9'b11111_1100;
         fire  = 1'b1;
      end
      else if (lu)     e.ctl = 9'b00111_0100;
      else             e.ctl = 9'b11111_0000;
      e.tmo  = m_tmo;
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
      exp_q.push_back(e);

      n_state = m_state; n_wait = m_wait; n_tmo = m_tmo;
      n_scnt = m_scnt; n_fcnt = m_fcnt;
      if (rst) begin
         n_state = 0; n_wait = 0; n_tmo = 1'b0; n_scnt = '0; n_fcnt = '0;
      end else begin
         if (!e.ctl[8]) n_scnt = m_scnt + 1'b1;
         if (fire)      n_fcnt = m_fcnt + 1'b1;
         if (m_state == 0 && mstall) begin
            n_state = 1; n_wait = 1;
         end else if (m_state == 1) begin
            if (!mstall) begin
               n_state = 0; n_wait = 0;
            end else if (m_wait == TO - 1) begin
               n_state = 2; n_tmo = 1'b1;
            end else begin
               n_wait = m_wait + 1;
            end
         end
      end

      @(negedge clk);
      o = exp_q.pop_front();
      check_eq("ctl", {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
                       if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}, o.ctl);
      check_eq("mem_timeout", tmo, o.tmo);
      check_eq("stall_cnt", scnt, o.scnt);
      check_eq("flush_cnt", fcnt, o.fcnt);
      @(posedge clk);
      #1;
      m_state = n_state; m_wait = n_wait; m_tmo = n_tmo;
      m_scnt = n_scnt; m_fcnt = n_fcnt;
   endtask

   task automatic idle();
      rst = 1'b0; rs1 = '0; rs2 = '0; exrd = '0;
      u1 = 1'b0; u2 = 1'b0; exv = 1'b0; exl = 1'b0;
      redir = 1'b0; mreq = 1'b0; mrdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic set_load_use(input logic [RW-1:0] rd);
      exv = 1'b1; exl = 1'b1; exrd = rd; rs2 = 5'd5; u2 = 1'b1;
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      check_eq("reset_scnt", scnt, 0);
      check_eq("reset_tmo", tmo, 0);

      // load-use: one bubble, then the load has left EX
      set_load_use(5'd5);
      cyc();
      idle();
      check_eq("lu_scnt", scnt, 1);
      cyc();
      set_load_use(5'd0);
      cyc();
      idle();
      check_eq("lu_rd0_scnt", scnt, 1);

      // redirect beats load-use
      do_reset();
      set_load_use(5'd5);
      redir = 1'b1;
      cyc();
      idle();
      check_eq("redir_fcnt", fcnt, 1);
      check_eq("redir_scnt", scnt, 0);

      // 3 stall cycles with redirect held, ready on 4th, redirect fires after
      do_reset();
      redir = 1'b1; mreq = 1'b1;
      repeat (3) cyc();
      mrdy = 1'b1;
      cyc();
      mreq = 1'b0; mrdy = 1'b0;
      cyc();
      idle();
      check_eq("memwait_scnt", scnt, 3);
      check_eq("memwait_fcnt", fcnt, 2);

      // hang: 4 stall cycles then HALT indefinitely
      do_reset();
      mreq = 1'b1;
      repeat (10) cyc();
      check_eq("halt_tmo", tmo, 1);
      check_eq("halt_wen", pc_wen | mem_wb_wen, 0);
      idle();
      cyc();
      do_reset();
      check_eq("post_rst_tmo", tmo, 0);
      check_eq("post_rst_scnt", scnt, 0);

      // ready on the last allowed stall cycle, then zero-wait, then request drop
      mreq = 1'b1;
      repeat (3) cyc();
      mrdy = 1'b1;
      cyc();
      cyc();
      check_eq("edge_tmo", tmo, 0);
      mrdy = 1'b0;
      repeat (2) cyc();
      mreq = 1'b0;
      repeat (2) cyc();
      idle();

      // counter wrap at 2^CW
      do_reset();
      set_load_use(5'd5);
      repeat (16) cyc();
      idle();
      check_eq("wrap_scnt", scnt, 0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         rst   = ($urandom_range(0, 39) == 0);
         rs1   = RW'($urandom_range(0, 3));
         rs2   = RW'($urandom_range(0, 3));
         exrd  = RW'($urandom_range(0, 3));
         u1    = 1'($urandom_range(0, 1));
         u2    = 1'($urandom_range(0, 1));
         exv   = 1'($urandom_range(0, 1));
         exl   = 1'($urandom_range(0, 1));
         redir = ($urandom_range(0, 3) == 0);
         mreq  = ($urandom_range(0, 2) == 0);
         mrdy  = 1'($urandom_range(0, 1));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
